cache_fill_fsm: RTL
===================

# cache_fill_fsm

Miss-handling controller that refills one 8-word line of the 64-line direct-mapped cache data array from multi-cycle main memory. On a miss it issues eight pipelined word reads to memory. It steers each returning word into the data array through one-hot block/word enables, then writes the tag array entry for the line. It sits directly upstream of the data array and tag array and downstream of the cache hit/miss compare logic.

## Interface
- No parameters; line geometry is fixed: 64 lines, 8 words/line, 16-bit words, byte addresses.
- Address split: tag = addr[15:10], index = addr[9:4], word = addr[3:1], addr[0] ignored.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- miss_detected  in  1  level; high when the current access missed
- miss_address  in  16  byte address of the missing access
- memory_data_valid  in  1  memory returns one word this cycle
- memory_data  in  16  returned word
- fsm_busy  out  1  high while a fill is in progress (FILL, TAG)
- mem_en  out  1  memory read request this cycle
- memory_address  out  16  request address
- data_write  out  1  write strobe to data array
- data_block_enable  out  64  one-hot line select to data array
- data_word_enable  out  8  one-hot word select to data array
- data_in  out  16  word to data array
- tag_write  out  1  write strobe to tag array
- tag_block_enable  out  64  one-hot line select to tag array
- tag_data  out  8  {valid=1, 1'b0, tag[5:0]}
- fill_done  out  1  one-cycle pulse when the line is complete

## Operation
- States: IDLE, FILL, TAG. Registers: base[15:4] (latched line address), issue_cnt[3:0] (0..8), recv_cnt[3:0] (0..8).
- IDLE:
  - fsm_busy=0.
  - If miss_detected=1 at a clock edge: latch base=miss_address[15:4], clear both counters, go to FILL.
- FILL:
  - mem_en=1 while issue_cnt<8.
  - memory_address={base, issue_cnt[2:0], 1'b0}.
  - issue_cnt increments on each cycle mem_en=1.
  - When memory_data_valid=1 and recv_cnt<8:
    - data_write=1, data_block_enable=onehot(base[9:4]), data_word_enable=onehot(recv_cnt[2:0]), data_in=memory_data.
    - recv_cnt increments.
  - When the 8th word is accepted (recv_cnt==7 and valid), go to TAG.
- TAG:
  - tag_write=1, tag_block_enable=onehot(base[9:4]), tag_data={1'b1,1'b0,base[15:10]}.
  - fill_done=1.
  - Unconditionally return to IDLE.
- All data-array and tag-array outputs are combinational from state, counters, base and memory_data_valid. When not writing, they are all zero: enables 0, strobes 0, data_in=0, memory_address=0.
- Words are assumed to return in request order. Gaps between valids are allowed. Memory latency is arbitrary, but at least 1 cycle.

## Timing
- Reset (async assert): state=IDLE, counters=0, base=0. All outputs are 0, including fsm_busy, mem_en and fill_done.
- Reset mid-fill aborts the fill immediately. Words already written remain in the data array, but the tag is never written, so the line stays invalid.
- Sequence:
  - miss sampled at edge N.
  - FILL occupies cycles N+1 onward; requests go out on cycles N+1..N+8, back-to-back.
  - With memory latency L, valids arrive on cycles N+1+L..N+8+L.
  - TAG occurs on cycle N+9+L; IDLE resumes on cycle N+10+L.
  - For L=4: busy for 13 cycles; fill_done at cycle N+13.
- miss_detected while busy is ignored. A miss still asserted in the first IDLE cycle after TAG starts a new fill.
- memory_data_valid in IDLE or TAG, or after 8 words have been received, is ignored: no data_write.
- A valid in the same cycle as a request is legal: issue and receive update independently.
- Back-to-back fills: IDLE lasts at least 1 cycle between fills.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release, no miss -> stays IDLE, mem_en=0.
- Basic fill, latency 4:
  - Stimulus: miss_address=0xA5C6, memory returns 0x1000+i.
  - Requests: addresses 0xA5C0,0xA5C2,...,0xA5CE on 8 consecutive cycles.
  - Data writes: data_block_enable bit 28 only, word enables 0x01..0x80 in order, data_in=0x1000..0x1007.
  - Tag: tag_data=0xA9, fill_done pulse at cycle N+13.
- Gapped returns: valid deasserted randomly between words -> exactly 8 data_write pulses, word order preserved, TAG only after the 8th word.
- Interference:
  - miss_detected toggled during FILL -> base unchanged.
  - Spurious valid in IDLE/TAG -> no data_write.
  - 9th valid -> no write.
- Reset mid-fill: assert rst_n after 3 words are received -> outputs 0 asynchronously, no tag_write. A new miss after release restarts at word 0.
- Back-to-back: miss held high across two fills (different addresses) -> second fill starts one cycle after the TAG cycle with the newly latched base.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Refills one 8-word line of the 64-line direct-mapped cache from main memory on a miss.
// Latency: 8 back-to-back reads issued from the cycle after the miss; the tag is written the cycle after the 8th word returns.
// No backpressure: every returning word is written the cycle it arrives; misses are ignored while a fill is in progress.
module cache_fill_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        fsm_busy,
    output logic        mem_en,
    output logic [15:0] memory_address,
    output logic        data_write,
    output logic [63:0] data_block_enable,
    output logic [7:0]  data_word_enable,
    output logic [15:0] data_in,
    output logic        tag_write,
    output logic [63:0] tag_block_enable,
    output logic [7:0]  tag_data,
    output logic        fill_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] base, base_nxt;        // line address: {tag[5:0], index[5:0]}
    logic [3:0]  issue_cnt, issue_nxt;  // words requested so far, 0..8
    logic [3:0]  recv_cnt, recv_nxt;    // words written so far, 0..8
    logic [63:0] line_sel;

    // Byte offset within a word is never needed; the word offset is regenerated by issue_cnt.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, miss_address[3:0]};

    // One-hot line select shared by the data and tag arrays.
    assign line_sel = 64'd1 << base[5:0];

    // State, line address and word counters; reset aborts any fill in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            base      <= base_nxt;
            issue_cnt <= issue_nxt;
            recv_cnt  <= recv_nxt;
        end
    end

    // Next state plus all array/memory strobes; everything idles at zero when not writing.
    always_comb begin
        state_nxt         = state;
        base_nxt          = base;
        issue_nxt         = issue_cnt;
        recv_nxt          = recv_cnt;
        fsm_busy          = 1'b0;
        mem_en            = 1'b0;
        memory_address    = '0;
        data_write        = 1'b0;
        data_block_enable = '0;
        data_word_enable  = '0;
        data_in           = '0;
        tag_write         = 1'b0;
        tag_block_enable  = '0;
        tag_data          = '0;
        fill_done         = 1'b0;

        case (state)
            IDLE: begin
                if (miss_detected) begin
                    base_nxt  = miss_address[15:4];
                    issue_nxt = '0;
                    recv_nxt  = '0;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                // Requests and returns advance independently; a word may return while later ones are still being issued.
                if (issue_cnt < 4'd8) begin
                    mem_en         = 1'b1;
                    memory_address = {base, issue_cnt[2:0], 1'b0};
                    issue_nxt      = issue_cnt + 4'd1;
                end
                if (memory_data_valid && (recv_cnt < 4'd8)) begin
                    data_write        = 1'b1;
                    data_block_enable = line_sel;
                    data_word_enable  = 8'd1 << recv_cnt[2:0];
                    data_in           = memory_data;
                    recv_nxt          = recv_cnt + 4'd1;
                    if (recv_cnt == 4'd7) begin
                        state_nxt = TAG;
                    end
                end
            end
            TAG: begin
                fsm_busy         = 1'b1;
                tag_write        = 1'b1;
                tag_block_enable = line_sel;
                tag_data         = {1'b1, 1'b0, base[11:6]};
                fill_done        = 1'b1;
                state_nxt        = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
